framebuffer_ram: RTL and testbench

Parametrised successor of the simple dual-port framebuffer RAM used by the VGA pipeline. It has one write port and one registered read port with a valid flag, plus a selectable read-during-write policy. An internal clear engine fills the whole memory with a colour, one word per clock. The drawing logic writes into it; the VGA scan-out reads from it.

---
 rtl/framebuffer_pkg.sv | 15 +
 rtl/framebuffer_ram_if.sv | 28 ++
 rtl/fb_clear_ctrl.sv | 73 +++++++
 rtl/framebuffer_ram.sv | 91 +++++++++
 tb/tb_framebuffer_ram.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/framebuffer_pkg.sv
// Shared types and default geometry for the VGA framebuffer RAM.
// The defaults describe a 320x240 screen at 3 bits per pixel.
package framebuffer_pkg;

    typedef enum logic [1:0] {
        FB_IDLE,
        FB_CLEAR,
        FB_DONE
    } fb_state_e;

    localparam int FB_WORD  = 3;
    localparam int FB_ABUS  = 17;
    localparam int FB_DEPTH = 76800;

endpackage

// File: rtl/framebuffer_ram_if.sv
// Framebuffer access bus: write port, registered read port and clear control.
// The drawing/scan-out side is the master and the RAM is the slave.
interface framebuffer_ram_if #(
    parameter int WordSize    = 3,
    parameter int Address_Bus = 17
);
    logic                   i_we;
    logic [Address_Bus-1:0] i_waddr;
    logic [WordSize-1:0]    i_write;
    logic                   i_re;
    logic [Address_Bus-1:0] i_raddr;
    logic [WordSize-1:0]    o_read;
    logic                   o_rvalid;
    logic                   i_clear;
    logic [WordSize-1:0]    i_clear_value;
    logic                   o_busy;
    logic                   o_done;

    modport master (
        output i_we, i_waddr, i_write, i_re, i_raddr, i_clear, i_clear_value,
        input  o_read, o_rvalid, o_busy, o_done
    );

    modport slave (
        input  i_we, i_waddr, i_write, i_re, i_raddr, i_clear, i_clear_value,
        output o_read, o_rvalid, o_busy, o_done
    );
endinterface

// File: rtl/fb_clear_ctrl.sv
// Clear engine: sweeps every framebuffer word with a captured colour,
// one word per clock, then pulses o_done for a single cycle.
module fb_clear_ctrl
    import framebuffer_pkg::*;
#(
    parameter int WordSize    = FB_WORD,
    parameter int Address_Bus = FB_ABUS,
    parameter int Address_Max = FB_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic [WordSize-1:0]    i_clear_value,
    output logic                   o_we,
    output logic [Address_Bus-1:0] o_addr,
    output logic [WordSize-1:0]    o_data,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam logic [Address_Bus-1:0] LAST_ADDR = Address_Bus'(Address_Max - 1);

    fb_state_e              state_q, state_d;
    logic [Address_Bus-1:0] cnt_q, cnt_d;
    logic [WordSize-1:0]    value_q, value_d;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= FB_IDLE;
            cnt_q   <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        unique case (state_q)
            FB_IDLE: begin
                if (i_clear) begin
                    state_d = FB_CLEAR;
                    cnt_d   = '0;
                    value_d = i_clear_value;
                end
            end
            FB_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = FB_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FB_DONE:  state_d = FB_IDLE;
            default:  state_d = FB_IDLE;
        endcase
    end

    // A reset mid-sweep aborts at once, so the word at the current count is not written.
    assign o_we   = (state_q == FB_CLEAR) && !i_rst;
    assign o_addr = cnt_q;
    assign o_data = value_q;
    assign o_busy = (state_q == FB_CLEAR);
    assign o_done = (state_q == FB_DONE);

endmodule

// File: rtl/framebuffer_ram.sv
// Framebuffer RAM: one write port, one registered read port with valid flag,
// selectable read-during-write policy and a built-in clear engine.
module framebuffer_ram
    import framebuffer_pkg::*;
#(
    parameter int WordSize    = FB_WORD,
    parameter int Address_Bus = FB_ABUS,
    parameter int Address_Max = FB_DEPTH,
    parameter int ReadNewData = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    framebuffer_ram_if.slave  bus
);

    localparam logic [Address_Bus:0] ADDR_LIMIT = (Address_Bus + 1)'(Address_Max);
    localparam bit                   BYPASS     = (ReadNewData != 0);

    if (longint'(Address_Max) > (longint'(1) << Address_Bus)) begin : g_depth_check
        $error("framebuffer_ram: Address_Max exceeds the address space of Address_Bus");
    end

    logic [WordSize-1:0]    mem [Address_Max];

    logic                   clr_we;
    logic [Address_Bus-1:0] clr_addr;
    logic [WordSize-1:0]    clr_data;

    logic                   mem_we;
    logic [Address_Bus-1:0] mem_waddr;
    logic [WordSize-1:0]    mem_wdata;
    logic                   waddr_ok;
    logic                   raddr_ok;

    fb_clear_ctrl #(
        .WordSize    (WordSize),
        .Address_Bus (Address_Bus),
        .Address_Max (Address_Max)
    ) u_clear (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_clear       (bus.i_clear),
        .i_clear_value (bus.i_clear_value),
        .o_we          (clr_we),
        .o_addr        (clr_addr),
        .o_data        (clr_data),
        .o_busy        (bus.o_busy),
        .o_done        (bus.o_done)
    );

    assign waddr_ok = {1'b0, bus.i_waddr} < ADDR_LIMIT;
    assign raddr_ok = {1'b0, bus.i_raddr} < ADDR_LIMIT;

    // The clear engine owns the write port while busy; user writes are dropped.
    always_comb begin
        mem_we    = bus.i_we && waddr_ok && !bus.o_busy;
        mem_waddr = bus.i_waddr;
        mem_wdata = bus.i_write;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = clr_data;
        end
    end

    // NOTE: the memory array has no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_read   <= '0;
            bus.o_rvalid <= 1'b0;
        end else begin
            bus.o_rvalid <= bus.i_re;
            if (bus.i_re) begin
                if (!raddr_ok) begin
                    bus.o_read <= '0;
                end else if (BYPASS && mem_we && (mem_waddr == bus.i_raddr)) begin
                    bus.o_read <= mem_wdata;
                end else begin
                    bus.o_read <= mem[bus.i_raddr];
                end
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_ram.sv
// Directed bench for framebuffer_ram: one instance per read-during-write policy.
module tb_framebuffer_ram;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    framebuffer_ram_if #(.WordSize(3), .Address_Bus(17)) bus0 ();
    framebuffer_ram_if #(.WordSize(3), .Address_Bus(17)) bus1 ();

    framebuffer_ram #(.WordSize(3), .Address_Bus(17), .Address_Max(76800), .ReadNewData(0)) dut0 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus0)
    );

    framebuffer_ram #(.WordSize(3), .Address_Bus(17), .Address_Max(76800), .ReadNewData(1)) dut1 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus1)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic rd0(input logic [16:0] a);
        bus0.i_re    = 1'b1;
        bus0.i_raddr = a;
        step();
        bus0.i_re    = 1'b0;
    endtask

    task automatic wr0(input logic [16:0] a, input logic [2:0] d);
        bus0.i_we    = 1'b1;
        bus0.i_waddr = a;
        bus0.i_write = d;
        step();
        bus0.i_we    = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        compared++;
        if (bus0.o_read !== 3'd0 || bus0.o_rvalid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_read: got read=%0h rvalid=%0b, want 0/0", bus0.o_read, bus0.o_rvalid);
        end
        compared++;
        if (bus0.o_busy !== 1'b0 || bus0.o_done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_clear: got busy=%0b done=%0b, want 0/0", bus0.o_busy, bus0.o_done);
        end
    endtask

    task automatic test_write_read();
        wr0(17'd100, 3'h5);
        rd0(17'd100);
        compared++;
        if (bus0.o_read !== 3'h5 || bus0.o_rvalid !== 1'b1) begin
            mismatched++;
            $display("FAIL read_100: got read=%0h rvalid=%0b, want 5/1", bus0.o_read, bus0.o_rvalid);
        end
        step();
        compared++;
        if (bus0.o_rvalid !== 1'b0 || bus0.o_read !== 3'h5) begin
            mismatched++;
            $display("FAIL idle_hold: got read=%0h rvalid=%0b, want 5/0", bus0.o_read, bus0.o_rvalid);
        end
    endtask

    task automatic test_read_during_write();
        bus0.i_we = 1'b1; bus0.i_waddr = 17'd7; bus0.i_write = 3'h1;
        bus1.i_we = 1'b1; bus1.i_waddr = 17'd7; bus1.i_write = 3'h1;
        step();
        bus0.i_write = 3'h3; bus0.i_re = 1'b1; bus0.i_raddr = 17'd7;
        bus1.i_write = 3'h3; bus1.i_re = 1'b1; bus1.i_raddr = 17'd7;
        step();
        bus0.i_we = 1'b0;
        bus1.i_we = 1'b0;
        compared++;
        if (bus0.o_read !== 3'h1) begin
            mismatched++;
            $display("FAIL rdw_old: got %0h, want 1", bus0.o_read);
        end
        compared++;
        if (bus1.o_read !== 3'h3) begin
            mismatched++;
            $display("FAIL rdw_new: got %0h, want 3", bus1.o_read);
        end
        step();
        bus0.i_re = 1'b0;
        bus1.i_re = 1'b0;
        compared++;
        if (bus0.o_read !== 3'h3 || bus1.o_read !== 3'h3) begin
            mismatched++;
            $display("FAIL rdw_after: got %0h/%0h, want 3/3", bus0.o_read, bus1.o_read);
        end
    endtask

    task automatic test_out_of_range();
        wr0(17'd76799, 3'h6);
        wr0(17'd76800, 3'h2);
        rd0(17'd76800);
        compared++;
        if (bus0.o_read !== 3'h0 || bus0.o_rvalid !== 1'b1) begin
            mismatched++;
            $display("FAIL oor_read: got read=%0h rvalid=%0b, want 0/1", bus0.o_read, bus0.o_rvalid);
        end
        rd0(17'd76799);
        compared++;
        if (bus0.o_read !== 3'h6) begin
            mismatched++;
            $display("FAIL last_word: got %0h, want 6", bus0.o_read);
        end
        rd0(17'h1FFFF);
        compared++;
        if (bus0.o_read !== 3'h0 || bus0.o_rvalid !== 1'b1) begin
            mismatched++;
            $display("FAIL oor_top: got read=%0h rvalid=%0b, want 0/1", bus0.o_read, bus0.o_rvalid);
        end
    endtask

    // Full sweep with ignored writes, an ignored clear during CLEAR and during DONE.
    task automatic test_clear();
        int  n;
        bit  early_done;
        bit  mid_read_ok;
        n           = 0;
        early_done  = 1'b0;
        mid_read_ok = 1'b0;
        bus0.i_clear       = 1'b1;
        bus0.i_clear_value = 3'h4;
        step();
        bus0.i_clear = 1'b0;
        while (bus0.o_busy === 1'b1 && n < 80000) begin
            n++;
            if (bus0.o_done !== 1'b0) early_done = 1'b1;
            if (n == 32 && bus0.o_read === 3'h4 && bus0.o_rvalid === 1'b1) mid_read_ok = 1'b1;
            bus0.i_we    = (n == 10);
            bus0.i_waddr = 17'd5;
            bus0.i_write = 3'h7;
            bus0.i_clear       = (n == 20);
            bus0.i_clear_value = 3'h2;
            bus0.i_re    = (n == 31);
            bus0.i_raddr = 17'd0;
            step();
        end
        bus0.i_we = 1'b0; bus0.i_clear = 1'b0; bus0.i_re = 1'b0;
        compared++;
        if (n != 76800) begin
            mismatched++;
            $display("FAIL busy_len: got %0d cycles, want 76800", n);
        end
        compared++;
        if (early_done) begin
            mismatched++;
            $display("FAIL done_early: got done during busy, want none");
        end
        compared++;
        if (!mid_read_ok) begin
            mismatched++;
            $display("FAIL read_in_clear: got read=%0h, want 4 with rvalid", bus0.o_read);
        end
        compared++;
        if (bus0.o_done !== 1'b1 || bus0.o_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL done_pulse: got done=%0b busy=%0b, want 1/0", bus0.o_done, bus0.o_busy);
        end
        bus0.i_clear = 1'b1; bus0.i_clear_value = 3'h2;
        wr0(17'd6, 3'h3);
        bus0.i_clear = 1'b0;
        compared++;
        if (bus0.o_done !== 1'b0 || bus0.o_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL after_done: got done=%0b busy=%0b, want 0/0", bus0.o_done, bus0.o_busy);
        end
        step();
        compared++;
        if (bus0.o_done !== 1'b0 || bus0.o_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL no_restart: got done=%0b busy=%0b, want 0/0", bus0.o_done, bus0.o_busy);
        end
        rd0(17'd0);
        compared++;
        if (bus0.o_read !== 3'h4) begin
            mismatched++;
            $display("FAIL clr_0: got %0h, want 4", bus0.o_read);
        end
        rd0(17'd38400);
        compared++;
        if (bus0.o_read !== 3'h4) begin
            mismatched++;
            $display("FAIL clr_38400: got %0h, want 4", bus0.o_read);
        end
        rd0(17'd76799);
        compared++;
        if (bus0.o_read !== 3'h4) begin
            mismatched++;
            $display("FAIL clr_76799: got %0h, want 4", bus0.o_read);
        end
        rd0(17'd5);
        compared++;
        if (bus0.o_read !== 3'h4) begin
            mismatched++;
            $display("FAIL write_in_clear: got %0h, want 4", bus0.o_read);
        end
        rd0(17'd6);
        compared++;
        if (bus0.o_read !== 3'h3) begin
            mismatched++;
            $display("FAIL write_in_done: got %0h, want 3", bus0.o_read);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit saw_done;
        saw_done = 1'b0;
        wr0(17'd999, 3'h1);
        wr0(17'd1000, 3'h1);
        bus0.i_clear       = 1'b1;
        bus0.i_clear_value = 3'h6;
        step();
        bus0.i_clear = 1'b0;
        repeat (1000) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        compared++;
        if (bus0.o_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_busy: got %0b, want 0", bus0.o_busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (bus0.o_done !== 1'b0) saw_done = 1'b1;
            step();
        end
        compared++;
        if (saw_done) begin
            mismatched++;
            $display("FAIL rst_done: got a done pulse, want none");
        end
        rd0(17'd999);
        compared++;
        if (bus0.o_read !== 3'h6) begin
            mismatched++;
            $display("FAIL partial_999: got %0h, want 6", bus0.o_read);
        end
        rd0(17'd1000);
        compared++;
        if (bus0.o_read !== 3'h1) begin
            mismatched++;
            $display("FAIL partial_1000: got %0h, want 1", bus0.o_read);
        end
        bus0.i_clear       = 1'b1;
        bus0.i_clear_value = 3'h2;
        step();
        bus0.i_clear = 1'b0;
        compared++;
        if (bus0.o_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL reclear: got busy=%0b, want 1", bus0.o_busy);
        end
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    initial begin
        bus0.i_we = 1'b0; bus0.i_waddr = '0; bus0.i_write = '0;
        bus0.i_re = 1'b0; bus0.i_raddr = '0;
        bus0.i_clear = 1'b0; bus0.i_clear_value = '0;
        bus1.i_we = 1'b0; bus1.i_waddr = '0; bus1.i_write = '0;
        bus1.i_re = 1'b0; bus1.i_raddr = '0;
        bus1.i_clear = 1'b0; bus1.i_clear_value = '0;
        test_reset();
        test_write_read();
        test_read_during_write();
        test_out_of_range();
        test_clear();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
